// File: rtl/config_frame_deserializer.sv
// Collects NUM_WORDS input words into one wide configuration frame and holds
// it in an output register. The collect buffer can fill the next frame while
// the consumer is stalled.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | output register holds no frame, out_valid_o = 0
// S_FULL  | output register holds a frame,  out_valid_o = 1
module config_frame_deserializer #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 5,
  parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [DATA_W-1:0]           in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [NUM_WORDS*DATA_W-1:0] out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [CNT_W-1:0]            count_o,
  output logic                        busy_o
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  // Only words 0..NUM_WORDS-2 are buffered; the completing word goes
  // straight from in_data_i into the output register.
  logic [(NUM_WORDS-1)*DATA_W-1:0]     buf_q;
  logic [NUM_WORDS*DATA_W-1:0]         out_q;
  logic [NUM_WORDS*DATA_W-1:0]         frame;
  logic                                last_word, accept, take, complete;

  assign last_word  = (count_q == CNT_W'(NUM_WORDS - 1));
  // Depends only on registered state and out_ready_i, never on in_valid_i.
  assign in_ready_o = !(last_word && (state_q == S_FULL) && !out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign take       = (state_q == S_FULL) && out_ready_i;
  assign complete   = accept && last_word;
  assign frame      = {in_data_i, buf_q};

  // Next output state and collect count; clear overrides beats and takes.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear_i) begin
      state_d = S_EMPTY;
      count_d = '0;
    end else begin
      if (complete)  state_d = S_FULL;
      else if (take) state_d = S_EMPTY;
      if (accept)    count_d = last_word ? '0 : count_q + CNT_W'(1);
    end
  end

  // State, count, indexed collect-buffer writes and output-register load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      buf_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept && !clear_i) begin
        for (int k = 0; k < NUM_WORDS - 1; k++) begin
          if (count_q == CNT_W'(k)) buf_q[k*DATA_W +: DATA_W] <= in_data_i;
        end
      end
      if (complete && !clear_i) out_q <= frame;
    end
  end

  assign out_valid_o = (state_q == S_FULL);
  assign out_data_o  = out_valid_o ? out_q : '0;
  assign count_o     = count_q;
  assign busy_o      = (count_q != '0);

endmodule

// File: tb/tb_config_frame_deserializer.sv
// Directed bench for config_frame_deserializer: default 32x5 build plus an
// 8x2 build sharing clock and reset.
module tb_config_frame_deserializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         clear = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [159:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   count;
  logic         busy;

  logic         clear2 = 1'b0;
  logic [7:0]   in2_data = '0;
  logic         in2_valid = 1'b0;
  logic         in2_ready;
  logic [15:0]  out2_data;
  logic         out2_valid;
  logic         out2_ready = 1'b0;
  logic [1:0]   count2;
  logic         busy2;

  int tests = 0;
  int fails = 0;
  int frames_seen;

  always #5 clk = ~clk;

  config_frame_deserializer dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .count_o(count), .busy_o(busy)
  );

  config_frame_deserializer #(.DATA_W(8), .NUM_WORDS(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear2),
    .in_data_i(in2_data), .in_valid_i(in2_valid), .in_ready_o(in2_ready),
    .out_data_o(out2_data), .out_valid_o(out2_valid), .out_ready_i(out2_ready),
    .count_o(count2), .busy_o(busy2)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] frame5(input logic [31:0] b);
    logic [159:0] f;
    for (int k = 0; k < 5; k++) f[k*32 +: 32] = b + 32'(k);
    return f;
  endfunction

  task automatic send5(input logic [31:0] base);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = base + 32'(k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_count", 160'(count), 160'd0);
    chk("rst_valid", 160'(out_valid), 160'd0);
    chk("rst_data", out_data, 160'd0);
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_ready", 160'(in_ready), 160'd1);

    // 1: basic frame
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h11 * 32'(i + 1);
      tick();
      chk("t1_count", 160'(count), 160'((i + 1) % 5));
    end
    in_valid = 1'b0;
    chk("t1_valid", 160'(out_valid), 160'd1);
    chk("t1_data", out_data,
        160'h00000055_00000044_00000033_00000022_00000011);
    tick();
    chk("t1_valid_drop", 160'(out_valid), 160'd0);
    chk("t1_data_zero", out_data, 160'd0);

    // 2: stall
    out_ready = 1'b0;
    send5(32'h01);
    chk("t2_valid", 160'(out_valid), 160'd1);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'hA0 + 32'(k);
      tick();
    end
    chk("t2_count4", 160'(count), 160'd4);
    in_data = 32'hA4;
    chk("t2_ready_low", 160'(in_ready), 160'd0);
    chk("t2_data_held", out_data, frame5(32'h01));
    tick();
    chk("t2_count_hold", 160'(count), 160'd4);
    chk("t2_data_held2", out_data, frame5(32'h01));
    out_ready = 1'b1;
    #1;
    chk("t2_ready_up", 160'(in_ready), 160'd1);
    tick();
    in_valid = 1'b0;
    chk("t2_valid_new", 160'(out_valid), 160'd1);
    chk("t2_data_new", out_data, frame5(32'hA0));
    chk("t2_count0", 160'(count), 160'd0);
    tick();
    chk("t2_valid_drop", 160'(out_valid), 160'd0);

    // 3: continuous stream of 20 words
    frames_seen = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h100 + 32'(i);
      chk("t3_ready", 160'(in_ready), 160'd1);
      tick();
      chk("t3_valid", 160'(out_valid), 160'(i % 5 == 4));
      if (out_valid) begin
        frames_seen++;
        chk("t3_data", out_data, frame5(32'h100 + 32'(i - 4)));
      end
    end
    in_valid = 1'b0;
    chk("t3_frames", 160'(frames_seen), 160'd4);
    tick();

    // 4: clear mid-frame, coincident with a beat
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hC0 + 32'(k);
      tick();
    end
    in_data = 32'hC3;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("t4_count", 160'(count), 160'd0);
    chk("t4_busy", 160'(busy), 160'd0);
    chk("t4_valid", 160'(out_valid), 160'd0);
    send5(32'hD0);
    chk("t4_valid_new", 160'(out_valid), 160'd1);
    chk("t4_data_clean", out_data, frame5(32'hD0));
    tick();

    // 5: clear while output stalled
    out_ready = 1'b0;
    send5(32'hE0);
    chk("t5_valid", 160'(out_valid), 160'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_valid_clr", 160'(out_valid), 160'd0);
    chk("t5_data_clr", out_data, 160'd0);

    // 6: 8-bit x 2-word build, then async reset mid-frame
    in2_valid = 1'b1;
    in2_data  = 8'hAB;
    tick();
    chk("t6_count1", 160'(count2), 160'd1);
    in2_data = 8'hCD;
    tick();
    chk("t6_valid", 160'(out2_valid), 160'd1);
    chk("t6_data", 160'(out2_data), 160'hCDAB);
    chk("t6_count0", 160'(count2), 160'd0);
    in2_data = 8'h12;
    tick();
    in2_valid = 1'b0;
    chk("t6_busy", 160'(busy2), 160'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 160'(out2_valid), 160'd0);
    chk("t6_rst_data", 160'(out2_data), 160'd0);
    chk("t6_rst_count", 160'(count2), 160'd0);
    chk("t6_rst_busy", 160'(busy2), 160'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_valid", 160'(out2_valid), 160'd0);
    chk("t6_post_ready", 160'(in2_ready), 160'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/config_frame_deserializer.md
Name: config_frame_deserializer

Overview:
Parametrised successor to the fixed 5×32-bit kernel-configuration deserializer. It collects NUM_WORDS beats of DATA_W bits from a valid/ready word stream and assembles them into one wide configuration frame. Each frame is presented on a valid/ready output port. A double buffer (collect buffer plus output register) lets assembly of the next frame overlap with a stalled consumer. The block sits between the configuration word stream and the CGRA kernel-configuration consumer.

Parameters:
DATA_W, 32, width of one input word in bits (>=1).
NUM_WORDS, 5, words per frame (>=2).
CNT_W, $clog2(NUM_WORDS+1), width of count_o (derived; do not override).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
clear_i  input  1  synchronous flush of the partial frame and the pending output frame.
in_data_i  input  DATA_W  input word.
in_valid_i  input  1  input word valid.
in_ready_o  output  1  block accepts in_data_i this cycle.
out_data_o  output  NUM_WORDS*DATA_W  assembled frame; word k occupies bits [k*DATA_W +: DATA_W].
out_valid_o  output  1  frame available.
out_ready_i  input  1  consumer takes the frame this cycle.
count_o  output  CNT_W  number of words held in the collect buffer (0..NUM_WORDS-1).
busy_o  output  1  count_o != 0.

Behaviour:
- Reset (rst_ni low, asynchronous): collect buffer and output register cleared to 0; count_o = 0; out_valid_o = 0; busy_o = 0; out_data_o = 0; in_ready_o = 1 once reset is released.
- Handshakes:
  - Input beat accepted when in_valid_i && in_ready_o.
  - Output frame taken when out_valid_o && out_ready_i.
  - in_valid_i is permitted to depend on in_ready_o.
  - No combinational path from in_valid_i to in_ready_o.
- Collect buffer writes by index, not by shifting. An accepted beat writes word[count] <= in_data_i, then count increments.
- Word ordering: the first accepted word of a frame is word 0 (LSBs); the last is word NUM_WORDS-1 (MSBs).
- Frame completion (beat accepted with count == NUM_WORDS-1):
  - Full frame, including the completing beat, is copied into the output register.
  - out_valid_o = 1 on the next cycle.
  - count wraps to 0.
  - Latency from last beat accepted to out_valid_o high: 1 cycle.
- Output state machine:
  - EMPTY: out_valid_o = 0. Frame completion → FULL.
  - FULL: out_valid_o = 1; out_data_o stable until taken.
    - Take without simultaneous completion → EMPTY.
    - Take with simultaneous completion → stay FULL, new frame loaded.
- Back-pressure: in_ready_o = !(count == NUM_WORDS-1 && out_valid_o && !out_ready_i). Words 0..NUM_WORDS-2 of the next frame are always accepted while the output is stalled.
- out_data_o is driven 0 whenever out_valid_o = 0.
- clear_i has priority over every other event in the same cycle:
  - count -> 0 and out_valid_o -> 0 next cycle.
  - Any beat or take in that cycle is discarded.
  - Buffer contents need not be zeroed.
  - in_ready_o is unaffected by clear_i.
- Throughput: with out_ready_i held high, one word per cycle is sustained indefinitely; one frame every NUM_WORDS cycles.
- Reset asserted mid-frame: partial frame and pending output are discarded with no out_valid_o glitch after release.

Test Plan:
1. Reset, defaults (DATA_W=32, NUM_WORDS=5): send 0x11,0x22,0x33,0x44,0x55 back-to-back with out_ready_i=1 → one cycle after 0x55, out_valid_o=1 and out_data_o=0x00000055_00000044_00000033_00000022_00000011 for 1 cycle; count_o goes 1,2,3,4,0.
2. Stall: complete a frame with out_ready_i=0, then stream 0xA0..0xA4 → 0xA0..0xA3 accepted (count_o=4); in_ready_o=0 while 0xA4 is offered; out_data_o unchanged. Raise out_ready_i → 0xA4 accepted that cycle; the next cycle shows frame A0..A4 with out_valid_o=1.
3. Continuous stream of 20 words with out_ready_i=1 → 4 frames, each with out_valid_o pulsing 1 cycle every 5 cycles; in_ready_o never drops.
4. clear_i after 3 words, same cycle as a 4th beat → count_o=0; the 4th word is lost. The next 5 words form a clean frame; no stale words appear.
5. clear_i while out_valid_o=1 and out_ready_i=0 → out_valid_o=0 and out_data_o=0 next cycle.
6. Parametrised build DATA_W=8, NUM_WORDS=2: send 0xAB,0xCD → out_data_o=0xCDAB; count_o is 2 bits wide; asserting rst_ni low mid-frame → all outputs 0 asynchronously.
